// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit 7-seg scan sequencer with frame-aligned shadow commit (optional blink via DISP_BLINK_EN)
//   clk, rst             : clock, synchronous active-high reset
//   en                   : 1 = prescaler/scan run, 0 = frozen
//   upd_valid/upd_ready  : handshake for new contents (upd_hexs, upd_points, upd_les)
//   scan                 : digit select; hexs/points/LEs: committed contents
//   frame_done           : one-cycle pulse when scan wraps 3->0
//   blink_mask           : per-digit blink enable, only when DISP_BLINK_EN is defined
module display_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_hexs,
  input  logic [3:0]  upd_points,
  input  logic [3:0]  upd_les,
  output logic [1:0]  scan,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        frame_done
`ifdef DISP_BLINK_EN
  ,input logic [3:0]  blink_mask
`endif
);
  logic [DIV_W-1:0] div;
  logic pending;
  logic [15:0] sh_hexs;
  logic [3:0] sh_points, sh_les, les_q;
  logic slot_tick, frame_tick, take, commit;
  assign upd_ready = ~pending;
  assign slot_tick = en && div == DIV_W'(SCAN_DIV - 1);
  assign frame_tick = slot_tick && scan == 2'd3;
  assign take = upd_valid && !pending;
  // take and commit are mutually exclusive: commit needs pending, take needs ~pending
  assign commit = frame_tick && pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      scan <= 2'd0;
      frame_done <= 1'b0;
      pending <= 1'b0;
      sh_hexs <= 16'h0;
      sh_points <= 4'h0;
      sh_les <= 4'h0;
      hexs <= 16'h0;
      points <= 4'h0;
      les_q <= 4'h0;
    end else begin
      if (en) div <= slot_tick ? '0 : div + DIV_W'(1);
      if (slot_tick) scan <= scan + 2'd1;
      frame_done <= frame_tick;
      if (take) begin
        sh_hexs <= upd_hexs;
        sh_points <= upd_points;
        sh_les <= upd_les;
        pending <= 1'b1;
      end
      if (commit) begin
        hexs <= sh_hexs;
        points <= sh_points;
        les_q <= sh_les;
        pending <= 1'b0;
      end
    end
  end
`ifdef DISP_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;
  logic phase, cnt_wrap, phase_n;
  logic [3:0] les_n;
  assign cnt_wrap = frame_done && blink_cnt == BW'(BLINK_FRAMES - 1);
  assign phase_n = phase ^ cnt_wrap;
  assign les_n = commit ? sh_les : les_q;
  // forcing is folded into the LEs register so blink_mask never reaches LEs combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase <= 1'b0;
      LEs <= 4'h0;
    end else begin
      if (frame_done) blink_cnt <= cnt_wrap ? '0 : blink_cnt + BW'(1);
      phase <= phase_n;
      LEs <= les_n | (phase_n ? blink_mask : 4'h0);
    end
  end
`else
  assign LEs = les_q;
`endif
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencing controller for the 4-digit 7-segment scan datapath (the 4:1 digit/point/LE mux plus anode decoder). Generates the 2-bit `scan` select at a programmable slot rate. Accepts new display contents over a valid/ready handshake and holds them in a shadow buffer. Commits them only at a frame boundary (`scan` wrapping 3→0), so a frame never mixes old and new digits.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (>=2); one frame = 4*SCAN_DIV cycles
DIV_W, 17, width of slot prescaler; must satisfy 2^DIV_W >= SCAN_DIV
BLINK_FRAMES, 64, frames per blink half-period (used only with DISP_BLINK_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  1 = scanning runs; 0 = prescaler and scan frozen
upd_valid  in  1  new display contents offered
upd_ready  out  1  controller can accept contents (= ~pending)
upd_hexs  in  16  four 4-bit digit codes, digit0 in [3:0]
upd_points  in  4  per-digit decimal point
upd_les  in  4  per-digit LE bit
scan  out  2  digit select to scan mux
hexs  out  16  committed digit codes to scan mux
points  out  4  committed points to scan mux
LEs  out  4  committed LE bits to scan mux
frame_done  out  1  one-cycle pulse on each frame boundary
blink_mask  in  4  per-digit blink enable (present only with DISP_BLINK_EN)

Behaviour:
- Clock `clk` is the only clock. `rst` is synchronous, active-high; it overrides all other inputs.
- Reset values: `scan`=0, `hexs`=16'h0000, `points`=4'h0, `LEs`=4'h0, `frame_done`=0, prescaler=0, `pending`=0 (so `upd_ready`=1), blink counter=0, blink phase=0.
- Prescaler (DIV_W bits), when `en`=1:
  - counts 0..SCAN_DIV-1;
  - at SCAN_DIV-1 the `slot_tick` condition is true, the prescaler wraps to 0 and `scan` increments mod 4.
- `en`=0: prescaler and `scan` hold; committed outputs hold; the handshake still accepts one update, which remains pending.
- Frame boundary = `slot_tick` while `scan`==3. In that cycle's next state:
  - `scan`→0 and `frame_done`=1 for exactly one cycle;
  - if `pending`=1: copy shadow→`hexs`/`points`/`LEs`, clear `pending`.
  - New values appear in the same cycle `scan` reads 0.
- Handshake: transfer when `upd_valid`&`upd_ready`.
  - Shadow captures `upd_hexs`/`upd_points`/`upd_les` and `pending` is set; `upd_ready` drops the following cycle.
  - `upd_valid` is not required to hold after transfer. No data is lost or overwritten while pending.
  - `upd_ready` reasserts the cycle after the committing boundary. A transfer can never coincide with a commit, because `ready`=0 while `pending`.
- Commit latency: transfer at cycle t → outputs change at the first frame boundary strictly after t. This is at most 4*SCAN_DIV cycles, more if `en` is low.
- Reset mid-frame or mid-pending:
  - shadow contents discarded;
  - outputs return to reset values on the next edge;
  - scanning restarts at `scan`=0, prescaler=0.
- Outputs `scan`/`hexs`/`points`/`LEs`/`frame_done` are all registered; no combinational path from inputs to them. `upd_ready` is combinational from `pending` only.

Optional Feature:
Macro DISP_BLINK_EN.
- Defined:
  - `blink_mask` port exists;
  - a frame counter (0..BLINK_FRAMES-1, counts on `frame_done`) toggles blink phase on wrap;
  - while phase=1, `LEs[i]` is driven 1 for each i with `blink_mask[i]`=1 (digit blanked), otherwise the committed LE bit;
  - forcing is combined in a register, so still no input→output combinational path;
  - reset clears counter and phase.
- Not defined: `blink_mask` port absent, no counter logic; `LEs` equals the committed LE register.

Test Plan:
1. Bench parameters SCAN_DIV=4, BLINK_FRAMES=2. Reset 3 cycles, `en`=1 → `scan` sequence 0,0,0,0,1,1,1,1,2…; `frame_done` pulses every 16 cycles, coincident with `scan`→0; all data outputs 0.
2. Mid-frame (`scan`=1) offer `upd_hexs`=16'h1234, `upd_points`=4'h5, `upd_les`=4'hA, `valid` one cycle → `upd_ready`=0 next cycle. `hexs` stays 0000 until the `scan` 3→0 edge, then becomes 1234/5/A. `upd_ready`=1 the cycle after.
3. While pending, hold `upd_valid`=1 with 16'hBEEF → not accepted, committed value is still the first update. After commit, BEEF accepted and applied at the following boundary.
4. Drop `en`=0 at `scan`=2 for 20 cycles → `scan` stays 2, no `frame_done`. Resume → prescaler continues from the held count; the frame completes normally.
5. Assert `rst` one cycle while `pending`=1 and `scan`=3 → next cycle all outputs 0, `upd_ready`=1. The pending update is never displayed.
6. DISP_BLINK_EN defined, `blink_mask`=4'b0011, committed `LEs`=4'h0 → `LEs`=4'h0 for 2 frames, 4'h3 for 2 frames, repeating. Without the macro, `LEs` stays 4'h0.
